iter_divider: RTL
=================

Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring integer divider for the EX stage.
- It is the responder side of the divider stream handshake that EX drives. It accepts dividend and divisor on two valid/ready channels, iterates one quotient bit per cycle, and returns {quotient, remainder} with a one-cycle result-valid pulse.
- The team instantiates it twice: SIGNED=1 for div.w/mod.w and SIGNED=0 for div.wu/mod.wu. These instances replace the vendor divider IP and keep its port names and dout packing.

Parameters:
- WIDTH, 32, operand width in bits.
- SIGNED, 1, 1 = two's-complement operands and results; 0 = unsigned.

Ports:
- clk  in  1  clock, rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tready  out  1  dividend ready.
- s_axis_dividend_tdata  in  WIDTH  dividend.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tready  out  1  divisor ready.
- s_axis_divisor_tdata  in  WIDTH  divisor.
- m_axis_dout_tvalid  out  1  result valid; one-cycle pulse; no back-pressure.
- m_axis_dout_tdata  out  2*WIDTH  [2W-1:W] = quotient, [W-1:0] = remainder.

Behaviour:
- Reset (asynchronous, resetn low):
  - state = IDLE; both capture flags clear; counter = 0.
  - Both treadys = 0, m_axis_dout_tvalid = 0, m_axis_dout_tdata = 0.
  - Reset asserted mid-operation aborts the division; no result is produced.
- tready outputs are registered. They rise on the first clk edge after reset release and stay 1 while in IDLE for any channel not yet captured.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Each channel is captured independently on its own valid&ready edge. A captured channel's tready drops at the next edge.
  - Both channels in the same cycle is the normal case.
  - When both operands are held (either captured this edge or earlier), go to BUSY on that same edge. Call that edge the acceptance edge, A.
  - Operands are registered at capture; later tdata changes are ignored.
- Setup at acceptance (SIGNED=1): load operand magnitudes. Record qneg = sign(dividend) XOR sign(divisor) and rneg = sign(dividend).
- BUSY:
  - Exactly WIDTH iterations, one per edge, driven by a counter from 0 to WIDTH-1.
  - Each iteration: shift partial remainder left and bring in the next dividend MSB. Subtract the divisor magnitude; if the result is non-negative, keep it and set the quotient bit to 1, else restore and set the bit to 0.
  - The remainder register is WIDTH+1 bits wide to hold the borrow.
  - The last iteration transitions to DONE.
- DONE (one cycle):
  - m_axis_dout_tvalid = 1 for exactly this cycle, i.e. high in the cycle after edge A+WIDTH+1.
  - Sign fixup (SIGNED=1): negate the quotient if qneg; negate the remainder if rneg.
  - Next edge: return to IDLE, clear capture flags, raise both treadys.
- Latency: result valid WIDTH+2 cycles after the acceptance cycle (34 for WIDTH=32). Throughput: one division per WIDTH+3 cycles.
- Both treadys are 0 throughout BUSY and DONE. No new operand is accepted until back in IDLE.
- m_axis_dout_tdata holds its last result after tvalid falls, until the next DONE.
- Divide by zero (divisor == 0, both modes): quotient = all ones, remainder = original dividend (unmodified, sign preserved). tvalid timing is unchanged.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This falls out of the magnitude arithmetic; no special case is needed.
- Identities:
  - Remainder magnitude < divisor magnitude.
  - dividend = quotient*divisor + remainder (mod 2^WIDTH).
  - A zero remainder is never negated to a nonzero value.
- tvalid deasserted after its channel was captured: no effect. A tvalid held high into the next IDLE is captured again as a new request.

Test Plan:
- Reset, then unsigned 100 / 7, both channels in the same cycle -> after acceptance, tvalid pulses exactly once, 34 cycles later; tdata = {0x0000000E, 0x00000002}; both treadys return to 1 the cycle after.
- SIGNED=1: -7 / 2 -> {0xFFFFFFFD, 0xFFFFFFFF}. 7 / -2 -> {0xFFFFFFFD, 0x00000001}. 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}.
- Divide by zero: unsigned 0x12345678 / 0 -> {0xFFFFFFFF, 0x12345678}. Signed -5 / 0 -> {0xFFFFFFFF, 0xFFFFFFFB}.
- Staggered channels: dividend valid at cycle 0, divisor valid at cycle 5 -> dividend_tready drops at cycle 1; acceptance edge = cycle 5; tvalid in cycle 5+34. Altering dividend tdata during cycles 1-5 does not change the result.
- Back-to-back: both tvalids held high continuously with 0xFFFFFFFF / 0x10 -> a new request is accepted every 35 cycles, each returning {0x0FFFFFFF, 0x0000000F}; no tready high during BUSY/DONE.
- Assert resetn low at iteration 10 -> tvalid and tdata immediately 0; after release, 9 / 3 completes correctly with {3, 0} and no stale pulse.

Source files
------------

// File: rtl/iter_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : iter_divider_if
// Brief    : Operand/result stream bundle for the iterative divider.
//            master = EX stage (operand producer), slave = divider.
// Revision : 1.0 - initial release
// ============================================================================
interface iter_divider_if #(
    parameter int WIDTH = 32
) ();

    logic                   s_axis_dividend_tvalid;
    logic                   s_axis_dividend_tready;
    logic [WIDTH-1:0]       s_axis_dividend_tdata;
    logic                   s_axis_divisor_tvalid;
    logic                   s_axis_divisor_tready;
    logic [WIDTH-1:0]       s_axis_divisor_tdata;
    logic                   m_axis_dout_tvalid;
    logic [2*WIDTH-1:0]     m_axis_dout_tdata;

    modport master (
        output s_axis_dividend_tvalid,
        output s_axis_dividend_tdata,
        input  s_axis_dividend_tready,
        output s_axis_divisor_tvalid,
        output s_axis_divisor_tdata,
        input  s_axis_divisor_tready,
        input  m_axis_dout_tvalid,
        input  m_axis_dout_tdata
    );

    modport slave (
        input  s_axis_dividend_tvalid,
        input  s_axis_dividend_tdata,
        output s_axis_dividend_tready,
        input  s_axis_divisor_tvalid,
        input  s_axis_divisor_tdata,
        output s_axis_divisor_tready,
        output m_axis_dout_tvalid,
        output m_axis_dout_tdata
    );

endinterface
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : iter_divider
// Brief    : Radix-2 restoring integer divider, one quotient bit per cycle.
//            Two independent operand channels, {quotient, remainder} result
//            with a single-cycle valid pulse. SIGNED selects two's-complement.
// Revision : 1.0 - initial release
// ============================================================================
module iter_divider #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    iter_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_dvd_ready;
    logic               r_dsr_ready;
    logic               r_dvd_held;
    logic               r_dsr_held;
    logic [WIDTH-1:0]   r_dvd_raw;
    logic [WIDTH-1:0]   r_dsr_raw;
    logic [WIDTH-1:0]   r_quo;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]     r_rem;        // extra bit holds the borrow
    logic [WIDTH-1:0]   r_dsr_mag;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_dzero;
    logic               r_dout_valid;
    logic [2*WIDTH-1:0] r_dout_data;

    // Channel capture: a handshake this cycle overrides the held copy
    logic               w_dvd_fire;
    logic               w_dsr_fire;
    logic               w_have_dvd;
    logic               w_have_dsr;
    logic               w_accept;
    logic [WIDTH-1:0]   w_dvd;
    logic [WIDTH-1:0]   w_dsr;
    logic               w_dvd_neg;
    logic               w_dsr_neg;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dsr_mag;

    assign w_dvd_fire = bus.s_axis_dividend_tvalid & r_dvd_ready;
    assign w_dsr_fire = bus.s_axis_divisor_tvalid  & r_dsr_ready;
    assign w_have_dvd = r_dvd_held | w_dvd_fire;
    assign w_have_dsr = r_dsr_held | w_dsr_fire;
    assign w_accept   = (r_state == IDLE) & w_have_dvd & w_have_dsr;
    assign w_dvd      = w_dvd_fire ? bus.s_axis_dividend_tdata : r_dvd_raw;
    assign w_dsr      = w_dsr_fire ? bus.s_axis_divisor_tdata  : r_dsr_raw;
    assign w_dvd_neg  = SIGNED & w_dvd[WIDTH-1];
    assign w_dsr_neg  = SIGNED & w_dsr[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -w_dvd : w_dvd;
    assign w_dsr_mag  = w_dsr_neg ? -w_dsr : w_dsr;

    // One restoring step: shift in next dividend bit, trial-subtract divisor
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, r_dsr_mag};
    assign w_qbit  = ~w_diff[WIDTH+1];

    // Sign fixup; divide-by-zero returns all-ones and the untouched dividend
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_quo_fix = r_dzero ? '1 : (r_qneg ? -r_quo : r_quo);
    assign w_rem_fix = r_dzero ? r_dvd_raw
                               : (r_rneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]);

    assign bus.s_axis_dividend_tready = r_dvd_ready;
    assign bus.s_axis_divisor_tready  = r_dsr_ready;
    assign bus.m_axis_dout_tvalid     = r_dout_valid;
    assign bus.m_axis_dout_tdata      = r_dout_data;

    // Control FSM, operand capture, iteration datapath and registered result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_dvd_ready  <= 1'b0;
            r_dsr_ready  <= 1'b0;
            r_dvd_held   <= 1'b0;
            r_dsr_held   <= 1'b0;
            r_dvd_raw    <= '0;
            r_dsr_raw    <= '0;
            r_quo        <= '0;
            r_rem        <= '0;
            r_dsr_mag    <= '0;
            r_qneg       <= 1'b0;
            r_rneg       <= 1'b0;
            r_dzero      <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
        end else begin
            r_dout_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_dvd_fire) begin
                        r_dvd_raw  <= bus.s_axis_dividend_tdata;
                        r_dvd_held <= 1'b1;
                    end
                    if (w_dsr_fire) begin
                        r_dsr_raw  <= bus.s_axis_divisor_tdata;
                        r_dsr_held <= 1'b1;
                    end
                    if (w_accept) begin
                        r_state     <= BUSY;
                        r_cnt       <= '0;
                        r_dvd_ready <= 1'b0;
                        r_dsr_ready <= 1'b0;
                        r_quo       <= w_dvd_mag;
                        r_rem       <= '0;
                        r_dsr_mag   <= w_dsr_mag;
                        r_qneg      <= w_dvd_neg ^ w_dsr_neg;
                        r_rneg      <= w_dvd_neg;
                        r_dzero     <= (w_dsr == '0);
                    end else begin
                        // Ready stays up only for a channel still waiting
                        r_dvd_ready <= ~w_have_dvd;
                        r_dsr_ready <= ~w_have_dsr;
                    end
                end
                BUSY: begin
                    if (r_cnt == CW'(WIDTH)) begin
                        // All bits resolved: publish the fixed-up result
                        r_state      <= DONE;
                        r_cnt        <= '0;
                        r_dout_valid <= 1'b1;
                        r_dout_data  <= {w_quo_fix, w_rem_fix};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                        r_rem <= w_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_dvd_held  <= 1'b0;
                    r_dsr_held  <= 1'b0;
                    r_dvd_ready <= 1'b1;
                    r_dsr_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
